// File: rtl/rv_rf_pkg.sv
// rv_rf_pkg
// Shared constants and types for the multi-read-port RV32I register file.
// Holds the default data width and register count, the hardwired zero
// register index, and the address/word typedefs used by the core.
// Configuration macro: RV_RF_BYPASS_EN (consumed by the top and scoreboard).
package rv_rf_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int REG_ZERO  = 0;

  typedef logic [4:0]          reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_word_t;

endpackage

// File: rtl/rv_rf_scoreboard.sv
// rv_rf_scoreboard
// Per-register busy tracking used by issue to detect RAW hazards against
// writebacks still in flight.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wrEn, i_wrAddr    writeback port (clears busy)
//   i_issueValid/Rd     issuing producer (sets busy)
//   i_rsAddr            NREAD packed read addresses
//   o_rsBusy            NREAD busy flags, combinational lookup
// Configuration macro: RV_RF_BYPASS_EN masks busy for a register being
// written back in the current cycle.
module rv_rf_scoreboard
  import rv_rf_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wrEn,
  input  logic [AW-1:0]       i_wrAddr,
  input  logic                i_issueValid,
  input  logic [AW-1:0]       i_issueRd,
  input  logic [NREAD*AW-1:0] i_rsAddr,
  output logic [NREAD-1:0]    o_rsBusy
);

  logic [NREGS-1:0] r_busy;
  logic             w_set;
  logic             w_clr;

  assign w_set = i_issueValid && (i_issueRd != AW'(REG_ZERO));
  assign w_clr = i_wrEn && (i_wrAddr != AW'(REG_ZERO));

  // The set is issued after the clear so that, for the same register on the
  // same edge, the newly issued producer keeps the register busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      if (w_clr) r_busy[i_wrAddr] <= 1'b0;
      if (w_set) r_busy[i_issueRd] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_busy
    logic [AW-1:0] w_addr;
    logic          w_stored;
    logic          w_busy;

    assign w_addr   = i_rsAddr[gi*AW +: AW];
    assign w_stored = (w_addr != AW'(REG_ZERO)) && r_busy[w_addr];

`ifdef RV_RF_BYPASS_EN
    // A writeback in this cycle already resolves the hazard for a consumer.
    assign w_busy = w_stored && !(w_clr && (w_addr == i_wrAddr));
`else
    assign w_busy = w_stored;
`endif

    assign o_rsBusy[gi] = !i_rst && w_busy;
  end

endmodule

// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp
// Multi-read-port integer register file: NREAD combinational read ports,
// one synchronous write port, synchronous clear on reset, and a busy
// scoreboard for hazard detection at issue.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   regWrite, rd, data   writeback port
//   rs_addr / rs_data    packed read ports (port i at [i*AW] / [i*XLEN])
//   issue_valid/issue_rd producer being issued this cycle
//   rs_busy              per-port pending-write flag
// Configuration macro: RV_RF_BYPASS_EN forwards the write data and clears
// busy for a read of the register being written in the same cycle.
module rv_regfile_mp
  import rv_rf_pkg::*;
#(
  parameter  int XLEN  = DEF_XLEN,
  parameter  int NREGS = DEF_NREGS,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       data,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [NREAD-1:0]      rs_busy
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wrEn;

  assign w_wrEn = regWrite && (rd != AW'(REG_ZERO));

  // Entry 0 is never written; reads of it are forced to zero below anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else if (w_wrEn) begin
      r_regs[rd] <= data;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_stored;
    logic [XLEN-1:0] w_data;

    assign w_addr   = rs_addr[gi*AW +: AW];
    assign w_stored = (w_addr == AW'(REG_ZERO)) ? '0 : r_regs[w_addr];

`ifdef RV_RF_BYPASS_EN
    assign w_data = (w_wrEn && (w_addr == rd)) ? data : w_stored;
`else
    assign w_data = w_stored;
`endif

    // Reset holds every port at zero, including any forwarded value.
    assign rs_data[gi*XLEN +: XLEN] = rst ? '0 : w_data;
  end

  rv_rf_scoreboard #(
    .NREGS(NREGS),
    .NREAD(NREAD)
  ) u_scoreboard (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wrEn      (regWrite),
    .i_wrAddr    (rd),
    .i_issueValid(issue_valid),
    .i_issueRd   (issue_rd),
    .i_rsAddr    (rs_addr),
    .o_rsBusy    (rs_busy)
  );

endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp
// Directed bench for rv_regfile_mp with four read ports. Stimulus pushes the
// expected read-port values into queues; a monitor compares them on the
// falling edge. Expectations follow RV_RF_BYPASS_EN when defined.
module tb_rv_regfile_mp;

`ifdef RV_RF_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          regWrite = 1'b0;
  logic [4:0]    rd = '0;
  logic [31:0]   data = '0;
  logic [19:0]   rs_addr = '0;
  logic [127:0]  rs_data;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd = '0;
  logic [3:0]    rs_busy;

  int assertCount = 0;
  int failCount   = 0;

  logic [127:0] expDataQ [$];
  logic [3:0]   expBusyQ [$];
  string        nameQ    [$];

  rv_regfile_mp #(
    .XLEN (32),
    .NREGS(32),
    .NREAD(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regWrite   (regWrite),
    .rd         (rd),
    .data       (data),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs_busy    (rs_busy)
  );

  always #5 clk = ~clk;

  // Drive the inputs for the next rising edge, just after the current one.
  task automatic applyStimulus(input logic rstV, input logic we, input logic [4:0] rdV,
                               input logic [31:0] dV, input logic iv, input logic [4:0] irdV);
    @(posedge clk);
    #1;
    rst         = rstV;
    regWrite    = we;
    rd          = rdV;
    data        = dV;
    issue_valid = iv;
    issue_rd    = irdV;
  endtask

  // Present read addresses and queue what the ports must show this cycle.
  task automatic checkOutput(input string name,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input logic [3:0] b);
    rs_addr = {a3, a2, a1, a0};
    expDataQ.push_back({d3, d2, d1, d0});
    expBusyQ.push_back(b);
    nameQ.push_back(name);
  endtask

  // Monitor: compare each queued expectation against the live outputs.
  always begin
    @(negedge clk);
    while (expDataQ.size() > 0) begin
      logic [127:0] ed;
      logic [3:0]   eb;
      string        nm;
      ed = expDataQ.pop_front();
      eb = expBusyQ.pop_front();
      nm = nameQ.pop_front();
      for (int p = 0; p < 4; p++) begin
        assertCount++;
        if (rs_data[p*32 +: 32] !== ed[p*32 +: 32]) begin
          failCount++;
          $display("[TB] FAIL %s data port %0d: got %h expected %h", nm, p,
                   rs_data[p*32 +: 32], ed[p*32 +: 32]);
        end
        assertCount++;
        if (rs_busy[p] !== eb[p]) begin
          failCount++;
          $display("[TB] FAIL %s busy port %0d: got %b expected %b", nm, p, rs_busy[p], eb[p]);
        end
      end
    end
  end

  initial begin
    // Power-up reset, then fill every register and mark many busy.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int r = 1; r < 32; r++)
      applyStimulus(0, 1, 5'(r), $urandom, 1, 5'((r % 31) + 1));

    // Reset overrides a simultaneous write and issue.
    applyStimulus(1, 1, 4, 32'h77, 1, 6);
    for (int g = 0; g < 8; g++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("after_reset", 5'(4*g), 5'(4*g+1), 5'(4*g+2), 5'(4*g+3),
                  0, 0, 0, 0, 4'b0000);
    end

    // Register zero ignores writes and issues.
    applyStimulus(0, 1, 0, 32'hDEADBEEF, 1, 0);
    checkOutput("zero_write_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("zero_after", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

    // Write r5 then r31; reads one edge after each write.
    applyStimulus(0, 1, 5, 32'h12345678, 0, 0);
    applyStimulus(0, 1, 31, 32'hA5A5A5A5, 0, 0);
    checkOutput("r5_r31_mid", 5, 31, 5, 31,
                32'h12345678, BP ? 32'hA5A5A5A5 : 32'h0,
                32'h12345678, BP ? 32'hA5A5A5A5 : 32'h0, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r5_r31", 5, 31, 5, 31,
                32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 4'b0000);

    // Same-cycle read of a register being written (bypass dependent).
    applyStimulus(0, 0, 0, 0, 1, 7);
    applyStimulus(0, 1, 7, 32'hCAFEF00D, 0, 0);
    checkOutput("r7_write_cycle", 7, 7, 7, 7,
                BP ? 32'hCAFEF00D : 32'h0, BP ? 32'hCAFEF00D : 32'h0,
                BP ? 32'hCAFEF00D : 32'h0, BP ? 32'hCAFEF00D : 32'h0,
                BP ? 4'b0000 : 4'b1111);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r7_after", 7, 7, 7, 7,
                32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000);

    // Scoreboard: issue latency, set-wins, plain clear, distinct set/clear.
    applyStimulus(0, 0, 0, 0, 1, 9);
    checkOutput("r9_issue_cycle", 9, 9, 9, 9, 0, 0, 0, 0, 4'b0000);
    applyStimulus(0, 1, 9, 32'h11, 1, 9);
    checkOutput("r9_write_and_issue", 9, 9, 9, 9,
                BP ? 32'h11 : 32'h0, BP ? 32'h11 : 32'h0,
                BP ? 32'h11 : 32'h0, BP ? 32'h11 : 32'h0,
                BP ? 4'b0000 : 4'b1111);
    applyStimulus(0, 1, 9, 32'h22, 1, 10);
    checkOutput("r9_still_busy", 9, 9, 10, 10,
                BP ? 32'h22 : 32'h11, BP ? 32'h22 : 32'h11, 0, 0,
                BP ? 4'b0000 : 4'b0011);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r9_clear_r10_set", 9, 9, 10, 10,
                32'h22, 32'h22, 0, 0, 4'b1100);

    // Reset mid-operation discards the pending write and busy state.
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("r3_issue_cycle", 3, 3, 3, 3, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1, 1, 3, 32'h55, 0, 0);
    checkOutput("in_reset", 3, 5, 7, 9, 0, 0, 0, 0, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("after_mid_reset", 3, 5, 7, 10, 0, 0, 0, 0, 4'b0000);

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    assertCount++;
    if (expDataQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL queue_drain: %0d entries left, expected 0", expDataQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rv_regfile_mp.md
# rv_regfile_mp

Parametrised multi-read-port integer register file for the RV32I core, the successor to the single-write/dual-read file. It provides NREAD combinational read ports, one synchronous write port, a synchronous clear of all registers on reset, and a per-register busy scoreboard. The issue stage uses the scoreboard to detect read-after-write hazards against in-flight writebacks. It sits between decode/issue and writeback.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers; power of two, at least 2.
- NREAD, 2: number of read ports, 1 to 4.
- AW, $clog2(NREGS): derived address width; not for override.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- regWrite  in  1  write enable for the writeback port.
- rd  in  AW  write address.
- data  in  XLEN  write data.
- rs_addr  in  NREAD*AW  read addresses; port i is bits [i*AW +: AW].
- rs_data  out  NREAD*XLEN  read data; port i is bits [i*XLEN +: XLEN].
- issue_valid  in  1  an instruction that writes issue_rd is issuing this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- rs_busy  out  NREAD  bit i is set when rs_addr port i names a register with a pending write.

## Operation
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - Its busy bit is never set.
- Write: on a clock edge with regWrite=1, rd≠0 and rst=0, registers[rd] takes the value of data.
- Read: rs_data for port i is a purely combinational function of rs_addr port i and the current register contents. There is no latch and no sensitivity-list dependence.
- Scoreboard: one busy bit per register.
  - On an edge with issue_valid=1 and issue_rd≠0, busy[issue_rd] is set.
  - On an edge with regWrite=1 and rd≠0, busy[rd] is cleared.
  - If the same register is set and cleared on the same edge, set wins: a new producer has been issued.
  - Set and clear on different registers on the same edge both take effect.
  - A write to a register that is not busy is legal and leaves the register not busy.
- rs_busy port i equals busy[rs_addr port i] and is combinational. It is 0 for address 0.
- Reset (rst=1 on an edge):
  - All registers are cleared to 0 and all busy bits are cleared.
  - Reset overrides a simultaneous write and a simultaneous issue.
  - Reset asserted mid-operation discards pending writes; there is no drain.
- Reset value of outputs: from the first edge with rst=1, rs_data is 0 on every port for every address and rs_busy is 0 on every port.

## Timing
- Write-to-read latency is one edge. Data written on edge N is visible on rs_data immediately after edge N.
- With RV_RF_BYPASS_EN defined, the write is also visible in the same cycle as the write.
- Issue-to-busy latency is one edge. An issue on edge N sets rs_busy for that register from after edge N.
- Writeback clears busy from after the write edge. With bypass enabled, rs_busy is also masked in the write cycle.
- Read paths are combinational from rs_addr to rs_data and rs_busy, with no registered outputs.
- Only clk is used.

## Configuration
- RV_RF_BYPASS_EN, when defined, enables same-cycle write-to-read forwarding:
  - When regWrite=1, rd≠0 and rs_addr port i equals rd, rs_data port i is driven from data and rs_busy port i is driven to 0.
  - The forwarding is combinational and applies to all ports independently.
- When undefined, reads return only stored contents. A read of rd in its write cycle returns the old value, and rs_busy stays set until after the edge.
- rst=1 suppresses forwarding in both configurations. Outputs remain 0 during reset cycles.

## Structure
- Package rv_rf_pkg holds:
  - the default XLEN (32) and NREGS (32) constants;
  - the REG_ZERO constant (0);
  - a typedef for a register address (logic [4:0]) and a typedef for a register word (logic [XLEN-1:0]).
- The scoreboard is the sub-module rv_rf_scoreboard, parametrised by NREGS and NREAD. It holds the busy vector, the set/clear/reset priority logic and the rs_busy lookup, including the bypass mask under the macro.
- The top module holds the storage array, the write logic, the read multiplexers and the forwarding logic.
- Read ports are generated with a generate loop over NREAD.

## Test plan
- Reset, then read all addresses: with rst=1 for 1 cycle after random writes, every port reads 0x00000000 for addresses 0 to 31 and rs_busy=0.
- Zero register: write 0xDEADBEEF to rd=0, then read address 0 on all ports → 0x00000000. Issue to rd=0 → rs_busy stays 0.
- Write then read on all ports: write 0x12345678 to r5 and 0xA5A5A5A5 to r31, then read r5, r31, r5, r31 with NREAD=4 → each port returns its register's value one edge after the write.
- Bypass: in the write cycle of 0xCAFEF00D to r7, read r7 → 0xCAFEF00D with the macro defined, and the old value 0 without it.
- Scoreboard: issue r9 → rs_busy=1 from the next cycle. Write r9 while issuing r9 on the same edge → busy stays 1. Write r9 alone → busy=0.
- Reset mid-operation: issue r3, then assert rst together with regWrite of r3=0x55 → after the edge r3 reads 0 and rs_busy=0.
